i2c_master_param: RTL and testbench
===================================

# i2c_master_param

Parametrised I2C master controller: the generalised successor to the team's fixed two-byte I2C transmitter. It performs a complete 7-bit-address transaction (START, address+R/W, N data bytes, STOP) in either write or read mode, with programmable SCL rate, ACK checking and NACK abort. It sits between the CPU-side register interface and the open-drain SDA/SCL pad logic.

## Interface
- N_BYTES, 2: data bytes per transaction (≥1).
- QTR, 1: clk cycles per SCL quarter-period (≥1). SCL period = 4·QTR clk cycles.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low; one clock domain.
- RNW  in  1  1 = read, 0 = write (I2C R/W bit value).
- I2C_ADDR  in  7  target address.
- WR_DATA  in  8·N_BYTES  write payload, most-significant byte sent first.
- START_STB  in  1  one-cycle request; honoured only when BUSY=0.
- SDA_IN  in  1  sampled bus SDA.
- SCL  out  1  bus clock.
- SDA_OUT  out  1  value driven on SDA when SDA_OE=1.
- SDA_OE  out  1  1 = master drives SDA, 0 = released.
- RD_DATA  out  8·N_BYTES  read payload, first byte received in MSBs.
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle pulse at transaction end.
- ACK_ERR  out  1  last transaction ended on a slave NACK; held until next START_STB.

## Operation
- Reset values: SCL=1, SDA_OUT=1, SDA_OE=0, RD_DATA=0, BUSY=0, DONE=0, ACK_ERR=0, state IDLE.
- States: IDLE → START → ADDR (8 bits) → ADDR_ACK → {WR_BYTE → WR_ACK | RD_BYTE → RD_ACK} ×N_BYTES → STOP → IDLE.
- IDLE: on START_STB capture RNW, I2C_ADDR, WR_DATA into internal registers; clear ACK_ERR; set BUSY. Inputs changing afterwards have no effect. START_STB while BUSY=1 is ignored.
- ADDR shifts {I2C_ADDR, RNW}, MSB first; WR_BYTE shifts captured bytes, MSB first.
- ADDR_ACK / WR_ACK: SDA_OE=0; SDA_IN sampled 1 → ACK_ERR=1, skip remaining bytes, go to STOP.
- RD_BYTE: SDA_OE=0, shift SDA_IN into byte register. RD_ACK: SDA_OE=1, SDA_OUT=0 (ACK) for bytes 1..N-1, SDA_OUT=1 (NACK) for byte N.
- RD_DATA updated atomically with the DONE pulse after a successful read; unchanged on write or aborted read.
- Asynchronous reset mid-transaction: all outputs return immediately to reset values (bus released); no STOP is generated.

## Timing
- Every state after IDLE occupies bit slots of four quarters Q0..Q3, each QTR clk cycles.
- Data/ACK slot: Q0–Q1 SCL=0, SDA updated at start of Q0; Q2–Q3 SCL=1; SDA_IN sampled on last cycle of Q2.
- START slot: Q0–Q1 SCL=1 SDA=1; Q2–Q3 SCL=1 SDA=0 (falling SDA with SCL high). SDA_OE=1.
- STOP slot: Q0–Q2 SDA=0 (SCL low Q0–Q1, high Q2); Q3 SCL=1 SDA=1; then SDA_OE=0.
- START slot begins the cycle after START_STB is sampled. Full transaction = (11 + 9·N_BYTES) slots = 4·QTR·(11 + 9·N_BYTES) cycles; DONE pulses and BUSY falls on the first cycle after the STOP slot.
- NACK abort length: ADDR NACK = 11 slots; WR_ACK NACK on byte k = (11 + 9·k) slots.
- No clock stretching; SCL is always master-driven.

## Structure
- Package i2c_pkg: state encoding localparams, quarter-phase constants (Q0..Q3), SCL/SDA idle-level constants.
- Sub-module i2c_phase_gen: QTR prescaler plus 2-bit quarter counter; outputs quarter tick, current quarter, slot-end strobe; held in reset (and restarted) while BUSY=0.
- Top level: FSM, bit counter (0..7), byte counter (0..N_BYTES-1), transmit/receive shift registers.

## Test plan
- Write, N_BYTES=2, QTR=1, I2C_ADDR=7'h5A, WR_DATA=16'hA53C, slave ACKs → SDA bytes 0xB4, 0xA5, 0x3C; DONE 116 cycles after START_STB; ACK_ERR=0.
- Address NACK (SDA_IN=1 in ADDR_ACK) → ACK_ERR=1, STOP follows immediately, DONE at cycle 44, no data slots.
- Read, I2C_ADDR=7'h21, slave returns 0xDE, 0xAD → address byte 0x43, master ACK after 0xDE, NACK after 0xAD, RD_DATA=16'hDEAD at DONE.
- START_STB pulse and WR_DATA change to 16'hFFFF during data byte 1 → ignored; original payload transmitted, single DONE.
- rst driven low mid WR_BYTE → same-cycle SCL=1, SDA_OE=0, BUSY=0; next START_STB yields a clean full transaction.
- QTR=3, N_BYTES=1 write → SCL period 12 cycles, DONE at cycle 240.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the parametrised I2C master: FSM encoding, quarter-phase
// names and bus idle levels.
package i2c_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_WR_BYTE  = 4'd4,
    ST_WR_ACK   = 4'd5,
    ST_RD_BYTE  = 4'd6,
    ST_RD_ACK   = 4'd7,
    ST_STOP     = 4'd8
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic SCL_IDLE = 1'b1;
  localparam logic SDA_IDLE = 1'b1;

  // SCL is low in the first half of a data/ACK/STOP slot and high in the second.
  function automatic logic scl_level(input logic [1:0] quarter);
    return quarter[1];
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Bit-slot timebase: QTR-cycle prescaler feeding a 2-bit quarter counter.
// Held at the start of Q0 whenever run_i is low so every transaction starts aligned.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int QTR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  output logic       tick_o,
  output logic [1:0] quarter_o,
  output logic       slot_end_o
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;

  always_comb begin
    tick_o     = run_i && (cnt_q == CNT_LAST);
    slot_end_o = tick_o && (qtr_q == Q3);
    quarter_o  = qtr_q;
    cnt_d      = cnt_q;
    qtr_d      = qtr_q;
    if (!run_i) begin
      cnt_d = '0;
      qtr_d = Q0;
    end else if (tick_o) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      qtr_q <= Q0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/i2c_master_param.sv
// I2C master: START, 7-bit address + R/W, N_BYTES data bytes (write or read), STOP.
// NACK from the slave aborts straight to STOP and latches ACK_ERR.
module i2c_master_param
  import i2c_pkg::*;
#(
  parameter int N_BYTES = 2,
  parameter int QTR     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RNW,
  input  logic [6:0]             I2C_ADDR,
  input  logic [8*N_BYTES-1:0]   WR_DATA,
  input  logic                   START_STB,
  input  logic                   SDA_IN,
  output logic                   SCL,
  output logic                   SDA_OUT,
  output logic                   SDA_OE,
  output logic [8*N_BYTES-1:0]   RD_DATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ACK_ERR,
  output logic [STATE_W-1:0]     dbg_state_o
);

  localparam int W  = 8 * N_BYTES;
  localparam int BW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(N_BYTES - 1);

  i2c_state_e    state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0]    tx_q, tx_d;
  logic [W-1:0]  payload_q, payload_d;
  logic [W-1:0]  rx_q, rx_d;
  logic [W-1:0]  rd_q, rd_d;
  logic          rnw_q, rnw_d;
  logic          ack_q, ack_d;
  logic          ack_err_q, ack_err_d;
  logic          done_q, done_d;

  logic       tick;
  logic [1:0] quarter;
  logic       slot_end;
  logic       sample;

  assign BUSY        = (state_q != ST_IDLE);
  assign DONE        = done_q;
  assign ACK_ERR     = ack_err_q;
  assign RD_DATA     = rd_q;
  assign dbg_state_o = state_q;
  assign sample      = tick && (quarter == Q2);

  i2c_phase_gen #(.QTR(QTR)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .run_i      (BUSY),
    .tick_o     (tick),
    .quarter_o  (quarter),
    .slot_end_o (slot_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    payload_d = payload_q;
    rx_d      = rx_q;
    rd_d      = rd_q;
    rnw_d     = rnw_q;
    ack_d     = ack_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START_STB) begin
          state_d   = ST_START;
          rnw_d     = RNW;
          tx_d      = {I2C_ADDR, RNW};
          payload_d = WR_DATA;
          rx_d      = '0;
          ack_err_d = 1'b0;
          bit_d     = 3'd0;
          byte_d    = '0;
        end
      end
      ST_START: begin
        if (slot_end) state_d = ST_ADDR;
      end
      ST_ADDR, ST_WR_BYTE: begin
        if (slot_end) begin
          tx_d  = {tx_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
        end
      end
      ST_ADDR_ACK, ST_WR_ACK: begin
        if (sample) ack_d = SDA_IN;
        if (slot_end) begin
          if (ack_q) begin
            ack_err_d = 1'b1;
            state_d   = ST_STOP;
          end else if (state_q == ST_ADDR_ACK && rnw_q) begin
            state_d = ST_RD_BYTE;
          end else if (state_q == ST_WR_ACK && byte_q == LAST_BYTE) begin
            state_d = ST_STOP;
          end else begin
            // Next payload byte: MSB-first, so the top byte of the captured word goes next.
            if (state_q == ST_WR_ACK) byte_d = byte_q + BW'(1);
            tx_d      = payload_q[W-1 -: 8];
            payload_d = payload_q << 8;
            state_d   = ST_WR_BYTE;
          end
        end
      end
      ST_RD_BYTE: begin
        if (sample) rx_d = {rx_q[W-2:0], SDA_IN};
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_RD_ACK;
        end
      end
      ST_RD_ACK: begin
        if (slot_end) begin
          if (byte_q == LAST_BYTE) begin
            state_d = ST_STOP;
          end else begin
            byte_d  = byte_q + BW'(1);
            state_d = ST_RD_BYTE;
          end
        end
      end
      ST_STOP: begin
        if (slot_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (rnw_q && !ack_err_q) rd_d = rx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    SCL     = SCL_IDLE;
    SDA_OUT = SDA_IDLE;
    SDA_OE  = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_START: begin
        SDA_OE  = 1'b1;
        SDA_OUT = ~quarter[1];
      end
      ST_ADDR, ST_WR_BYTE: begin
        SCL     = scl_level(quarter);
        SDA_OE  = 1'b1;
        SDA_OUT = tx_q[7];
      end
      ST_ADDR_ACK, ST_WR_ACK, ST_RD_BYTE: begin
        SCL = scl_level(quarter);
      end
      ST_RD_ACK: begin
        SCL     = scl_level(quarter);
        SDA_OE  = 1'b1;
        SDA_OUT = (byte_q == LAST_BYTE);
      end
      ST_STOP: begin
        SCL     = scl_level(quarter);
        SDA_OE  = 1'b1;
        SDA_OUT = (quarter == Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_q     <= 3'd0;
      byte_q    <= '0;
      tx_q      <= '0;
      payload_q <= '0;
      rx_q      <= '0;
      rd_q      <= '0;
      rnw_q     <= 1'b0;
      ack_q     <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      payload_q <= payload_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      rnw_q     <= rnw_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_param.sv
// Bench for i2c_master_param: scripted slave on the bus, frame and DONE scoreboards,
// plus a QTR=3 / N_BYTES=1 instance for SCL period and latency.
module tb_i2c_master_param;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: N_BYTES=2, QTR=1
  logic        rnw, start_stb, sda_in, scl, sda_out, sda_oe, busy, done, ack_err;
  logic [6:0]  i2c_addr;
  logic [15:0] wr_data, rd_data;
  logic [3:0]  dbg_state;
  logic        bus_sda;
  assign bus_sda = sda_oe ? sda_out : sda_in;

  i2c_master_param #(.N_BYTES(2), .QTR(1)) dut (
    .clk(clk), .rst(rst_n), .RNW(rnw), .I2C_ADDR(i2c_addr), .WR_DATA(wr_data),
    .START_STB(start_stb), .SDA_IN(sda_in), .SCL(scl), .SDA_OUT(sda_out),
    .SDA_OE(sda_oe), .RD_DATA(rd_data), .BUSY(busy), .DONE(done),
    .ACK_ERR(ack_err), .dbg_state_o(dbg_state)
  );

  // Slow instance: N_BYTES=1, QTR=3, slave always ACKs
  logic       rnw3, stb3, sda_in3, scl3, sda_out3, sda_oe3, busy3, done3, ack_err3;
  logic [6:0] addr3;
  logic [7:0] wr3, rd3;
  logic [3:0] dbg3;

  i2c_master_param #(.N_BYTES(1), .QTR(3)) dut3 (
    .clk(clk), .rst(rst_n), .RNW(rnw3), .I2C_ADDR(addr3), .WR_DATA(wr3),
    .START_STB(stb3), .SDA_IN(sda_in3), .SCL(scl3), .SDA_OUT(sda_out3),
    .SDA_OE(sda_oe3), .RD_DATA(rd3), .BUSY(busy3), .DONE(done3),
    .ACK_ERR(ack_err3), .dbg_state_o(dbg3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_start = 0;
  int t_start3 = 0;

  logic [8:0]  exp_byte_q[$];   // {byte, ack bit} per 9-bit bus frame
  logic [32:0] exp_q[$];        // {latency[15:0], ack_err, rd_data[15:0]} per DONE
  logic [32:0] exp3_q[$];

  // Slave script
  logic        slv_rnw = 1'b0;
  logic [15:0] slv_rd = 16'h0;
  int          slv_nack_frame = -1;
  int          slv_ne = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor + reactive slave, sampled on the falling clock edge
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [8:0] frame = '0;
  int         nbits = 0;
  always @(negedge clk) begin
    int fr_i, bit_i;
    logic v;
    if (prev_scl && scl && prev_sda && !bus_sda) begin
      nbits  = 0;
      slv_ne = 0;
    end
    if (!prev_scl && scl) begin
      frame = {frame[7:0], bus_sda};
      nbits++;
      if (nbits == 9) begin
        nbits = 0;
        if (exp_byte_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus frame: got unexpected frame 0x%0h, expected none", frame);
        end else begin
          chk("bus frame", frame, exp_byte_q.pop_front());
        end
      end
    end
    prev_sda = bus_sda;
    if (prev_scl && !scl) begin
      fr_i  = slv_ne / 9;
      bit_i = slv_ne % 9;
      slv_ne++;
      v = 1'b1;
      if (bit_i == 8) begin
        if (fr_i == 0 || !slv_rnw) v = (fr_i == slv_nack_frame);
      end else if (slv_rnw && fr_i >= 1 && fr_i <= 2) begin
        v = slv_rd[(2 - fr_i) * 8 + 7 - bit_i];
      end
      sda_in = v;
    end
    prev_scl = scl;
  end

  // DONE scoreboards and slow-instance SCL period monitor
  logic prev_scl3 = 1'b1;
  logic have_rise3 = 1'b0;
  int   last_rise3 = 0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done: got unexpected DONE at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done latency", 64'(cyc - t_start), 64'(e[32:17]));
        chk("ack_err at done", ack_err, e[16]);
        chk("rd_data at done", rd_data, e[15:0]);
      end
    end
    if (done3) begin
      if (exp3_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done3: got unexpected DONE at cycle %0d, expected none", cyc);
      end else begin
        e = exp3_q.pop_front();
        chk("dut3 done latency", 64'(cyc - t_start3), 64'(e[32:17]));
        chk("dut3 ack_err", ack_err3, e[16]);
        chk("dut3 rd_data", rd3, e[7:0]);
      end
    end
    if (!busy3) have_rise3 = 1'b0;
    else if (!prev_scl3 && scl3) begin
      if (have_rise3) chk("dut3 scl period", 64'(cyc - last_rise3), 64'd12);
      last_rise3 = cyc;
      have_rise3 = 1'b1;
    end
    prev_scl3 = scl3;
  end

  task automatic start1(input logic r, input logic [6:0] a, input logic [15:0] d);
    @(negedge clk);
    rnw = r; i2c_addr = a; wr_data = d; start_stb = 1'b1;
    @(posedge clk); #1;
    t_start = cyc;
    start_stb = 1'b0;
  endtask

  task automatic wait_idle(input logic sel3, input int budget, input string name);
    int n = 0;
    while ((sel3 ? busy3 : busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sel3 ? busy3 : busy) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got BUSY still 1 after %0d cycles, expected 0", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic slave_cfg(input logic r, input logic [15:0] rd, input int nack_frame);
    slv_rnw = r; slv_rd = rd; slv_nack_frame = nack_frame;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rnw = 1'b0; i2c_addr = '0; wr_data = '0; start_stb = 1'b0; sda_in = 1'b1;
    rnw3 = 1'b0; addr3 = '0; wr3 = '0; stb3 = 1'b0; sda_in3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset scl", scl, 1'b1);
    chk("reset sda_out", sda_out, 1'b1);
    chk("reset sda_oe", sda_oe, 1'b0);
    chk("reset rd_data", rd_data, 16'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset ack_err", ack_err, 1'b0);
    chk("reset state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x5A <- A5 3C, all ACKed
    slave_cfg(1'b0, 16'h0, -1);
    exp_byte_q.push_back({8'hB4, 1'b0});
    exp_byte_q.push_back({8'hA5, 1'b0});
    exp_byte_q.push_back({8'h3C, 1'b0});
    exp_q.push_back({16'd116, 1'b0, 16'h0000});
    start1(1'b0, 7'h5A, 16'hA53C);
    wait_idle(1'b0, 300, "write timeout");

    // Address NACK
    slave_cfg(1'b0, 16'h0, 0);
    exp_byte_q.push_back({8'hB4, 1'b1});
    exp_q.push_back({16'd44, 1'b1, 16'h0000});
    start1(1'b0, 7'h5A, 16'hA53C);
    wait_idle(1'b0, 300, "addr nack timeout");

    // Read 0x21 -> DE AD
    slave_cfg(1'b1, 16'hDEAD, -1);
    exp_byte_q.push_back({8'h43, 1'b0});
    exp_byte_q.push_back({8'hDE, 1'b0});
    exp_byte_q.push_back({8'hAD, 1'b1});
    exp_q.push_back({16'd116, 1'b0, 16'hDEAD});
    start1(1'b1, 7'h21, 16'h0000);
    wait_idle(1'b0, 300, "read timeout");

    // START_STB and input changes during data byte 1 must be ignored
    slave_cfg(1'b0, 16'h0, -1);
    exp_byte_q.push_back({8'hB4, 1'b0});
    exp_byte_q.push_back({8'hA5, 1'b0});
    exp_byte_q.push_back({8'h3C, 1'b0});
    exp_q.push_back({16'd116, 1'b0, 16'hDEAD});
    start1(1'b0, 7'h5A, 16'hA53C);
    repeat (45) @(negedge clk);
    chk("busy mid transaction", busy, 1'b1);
    start_stb = 1'b1; wr_data = 16'hFFFF; rnw = 1'b1; i2c_addr = 7'h7F;
    @(negedge clk);
    start_stb = 1'b0;
    wait_idle(1'b0, 300, "ignored stb timeout");

    // NACK on data byte 1
    slave_cfg(1'b0, 16'h0, 1);
    exp_byte_q.push_back({8'h78, 1'b0});
    exp_byte_q.push_back({8'h12, 1'b1});
    exp_q.push_back({16'd80, 1'b1, 16'hDEAD});
    start1(1'b0, 7'h3C, 16'h1234);
    wait_idle(1'b0, 300, "data nack timeout");

    // Asynchronous reset in WR_BYTE (slot 12, quarter 2)
    slave_cfg(1'b0, 16'h0, -1);
    exp_byte_q.push_back({8'hB4, 1'b0});
    start1(1'b0, 7'h5A, 16'hA53C);
    repeat (50) @(posedge clk);
    #1;
    chk("pre-reset scl high", scl, 1'b1);
    chk("pre-reset sda_oe", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset scl", scl, 1'b1);
    chk("async reset sda_oe", sda_oe, 1'b0);
    chk("async reset sda_out", sda_out, 1'b1);
    chk("async reset busy", busy, 1'b0);
    chk("async reset rd_data", rd_data, 16'h0);
    chk("async reset ack_err", ack_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean transaction after reset
    exp_byte_q.push_back({8'hB4, 1'b0});
    exp_byte_q.push_back({8'hA5, 1'b0});
    exp_byte_q.push_back({8'h3C, 1'b0});
    exp_q.push_back({16'd116, 1'b0, 16'h0000});
    start1(1'b0, 7'h5A, 16'hA53C);
    wait_idle(1'b0, 300, "post-reset timeout");

    // Slow instance: QTR=3, one byte
    exp3_q.push_back({16'd240, 1'b0, 16'h0000});
    @(negedge clk);
    rnw3 = 1'b0; addr3 = 7'h55; wr3 = 8'h81; stb3 = 1'b1;
    @(posedge clk); #1;
    t_start3 = cyc;
    stb3 = 1'b0;
    wait_idle(1'b1, 400, "dut3 timeout");

    chk("frames left over", 64'(exp_byte_q.size()), 64'd0);
    chk("dones left over", 64'(exp_q.size()), 64'd0);
    chk("dut3 dones left over", 64'(exp3_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
